booth_seq_mult: RTL and testbench

- Sequential radix-2 Booth multiplier for two's-complement operands. It is the datapath and controller stage that consumes the team's gate-level cell library.
- The add/subtract path is a WIDTH+1-bit ripple adder built from fa cells. Subtraction uses xor2 inversion of M plus carry-in 1.
- Accepts one operand pair per start, iterates one Booth step per clock, and returns a 2*WIDTH-bit signed product with a done pulse.

---
 rtl/booth_seq_mult.sv | 183 ++++++++++++++++++
 tb/tb_booth_seq_mult.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential radix-2 Booth multiplier for two's-complement operands.
//
// One operand pair is accepted per start. The multiplier performs one Booth step
// per clock and returns a 2*WIDTH-bit signed product with a one-cycle done pulse.
// The add/subtract path is a WIDTH+1-bit ripple adder made of fa cells. Subtraction
// inverts M through xor2 cells and injects a carry-in of 1.
//
// Optional feature (macro BOOTH_OPCOUNT_EN): adds the op_count output. It counts the
// Booth steps of the current or most recent operation that performed an add or a
// subtract.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   start        in   request; sampled only while idle
//   multiplicand in   [WIDTH-1:0]   signed M, captured on accepted start
//   multiplier   in   [WIDTH-1:0]   signed Q, captured on accepted start
//   busy         out  high while iterating
//   done         out  one-cycle pulse, product valid
//   product      out  [2*WIDTH-1:0] signed result, held until next completion
//   op_count     out  [$clog2(WIDTH+1)-1:0] add/sub step count (BOOTH_OPCOUNT_EN only)
//
// Handshake: start is accepted on a rising edge only when busy=0. From the edge
// after acceptance busy reads 1. A start seen while busy is dropped, not queued.
// done is high for exactly the one cycle following the final step, and busy is 0
// in that cycle. A start held high during the done cycle is therefore accepted
// immediately, with no idle cycle lost.

module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module xor2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

module booth_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
`ifdef BOOTH_OPCOUNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] op_count
`endif
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t            state, state_next;
    logic [WIDTH-1:0]  a_reg, q_reg, m_reg;
    logic              q_1;
    logic [CW-1:0]     count;
    logic              last_step;

    // Booth recoding of the current bit pair {Q[0], Q_1}.
    logic              do_op;     // 01 or 10: an add or a subtract happens
    logic              sub;       // 10: subtract M

    // WIDTH+1-bit add/subtract path. The extra bit keeps -2^(WIDTH-1) exact.
    logic [WIDTH:0]    a_ext, m_ext, m_sel, sum, a_new;
    logic [WIDTH:0]    carry;
    logic              carry_unused;
    logic [WIDTH-1:0]  a_shift, q_shift;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign last_step = (count == CW'(1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (last_step) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == CALC);

    // ---------------- Adder ----------------
    assign do_op = q_reg[0] ^ q_1;
    assign sub   = q_reg[0] & ~q_1;
    assign a_ext = {a_reg[WIDTH-1], a_reg};
    assign m_ext = {m_reg[WIDTH-1], m_reg};
    assign carry[0] = sub;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_inv
        xor2 u_xor (.a(m_ext[i]), .b(sub), .y(m_sel[i]));
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_add
        fa u_fa (.a(a_ext[i]), .b(m_sel[i]), .cin(carry[i]), .sum(sum[i]), .cout(carry[i+1]));
    end

    // The top cell's carry-out is discarded; sum[WIDTH] is already the correct sign.
    fa u_fa_msb (
        .a(a_ext[WIDTH]), .b(m_sel[WIDTH]), .cin(carry[WIDTH]),
        .sum(sum[WIDTH]), .cout(carry_unused)
    );

    assign a_new = do_op ? sum : a_ext;

    // The arithmetic right shift of {A,Q,Q_1} takes the sign from the wide sum, so
    // an intermediate overflow of WIDTH-bit A is shifted back into range.
    assign a_shift = a_new[WIDTH:1];
    assign q_shift = {a_new[0], q_reg[WIDTH-1:1]};

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg   <= '0;
            q_reg   <= '0;
            q_1     <= 1'b0;
            m_reg   <= '0;
            count   <= '0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= '0;
                        q_reg <= multiplier;
                        q_1   <= 1'b0;
                        m_reg <= multiplicand;
                        count <= CW'(WIDTH);
                    end
                end
                CALC: begin
                    a_reg <= a_shift;
                    q_reg <= q_shift;
                    q_1   <= q_reg[0];
                    count <= count - CW'(1);
                    if (last_step) begin
                        product <= {a_shift, q_shift};
                        done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BOOTH_OPCOUNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (state == IDLE && start) begin
            op_count <= '0;
        end else if (state == CALC && do_op) begin
            op_count <= op_count + CW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_booth_seq_mult.sv
// tb_booth_seq_mult: self-checking bench for booth_seq_mult (WIDTH=8).
// A transaction-level model predicts busy/done/product/op_count each cycle from
// the accepted operands (signed multiply, latency WIDTH edges). A compare process
// checks the DUT every negedge. Directed cases pin literal products and timing.

module tb_booth_seq_mult;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [W-1:0]       multiplicand;
    logic [W-1:0]       multiplier;
    logic               busy;
    logic               done;
    logic [2*W-1:0]     product;
`ifdef BOOTH_OPCOUNT_EN
    logic [CW-1:0]      op_count;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic chk_en = 1'b0;

    booth_seq_mult #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .multiplicand(multiplicand),
        .multiplier(multiplier),
        .busy(busy),
        .done(done),
        .product(product)
`ifdef BOOTH_OPCOUNT_EN
        ,
        .op_count(op_count)
`endif
    );

    // ---------------- Clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- Behavioural model ----------------
    logic           m_busy = 1'b0;
    logic           m_done = 1'b0;
    logic [2*W-1:0] m_prod = '0;
    logic [2*W-1:0] m_pend = '0;
    logic [W-1:0]   m_q    = '0;
    int             m_left = 0;
    int             m_steps = 0;

    // Booth adds/subtracts wherever a multiplier bit differs from the bit below it
    // (bit -1 reads as 0). Counts these positions among the first n steps.
    function automatic int transitions(input logic [W-1:0] q, input int n);
        int   c = 0;
        logic prev = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (q[i] != prev) c++;
            prev = q[i];
        end
        return c;
    endfunction

    always @(posedge clk) begin
        logic signed [W-1:0]   sa, sb;
        logic signed [2*W-1:0] p;
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_prod = '0; m_q = '0; m_steps = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (start) begin
                    sa = multiplicand; sb = multiplier;
                    p = sa * sb;
                    m_pend = p; m_q = multiplier;
                    m_busy = 1'b1; m_left = W; m_steps = 0;
                end
            end else begin
                m_left--; m_steps++;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_done = 1'b1; m_prod = m_pend;
                end
            end
        end
    end

    // ---------------- Scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done", 64'(done), 64'(m_done));
            chk("product", 64'(product), 64'(m_prod));
`ifdef BOOTH_OPCOUNT_EN
            chk("op_count", 64'(op_count), 64'(transitions(m_q, m_steps)));
`endif
        end
    end

    // ---------------- Driver tasks ----------------
    int start_cyc;

    // Called away from a rising edge; leaves time at 1 ns after the accepting edge.
    task automatic do_start(input logic [W-1:0] mc, input logic [W-1:0] mq);
        start = 1'b1; multiplicand = mc; multiplier = mq;
        @(posedge clk); #1;
        start_cyc = cyc;
        start = 1'b0;
    endtask

    // Returns at the negedge where done is high, or flags a timeout.
    task automatic wait_done(input int max_cycles);
        bit seen = 0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin seen = 1; break; end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout at cycle %0d: no done within %0d cycles", cyc, max_cycles);
        end
    endtask

    // ---------------- Stimulus ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_product", 64'(product), 64'd0);
`ifdef BOOTH_OPCOUNT_EN
        chk("reset_op_count", 64'(op_count), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // 3 * -4; done sits in the cycle after edge WIDTH counted from the start edge.
        do_start(8'd3, 8'hFC);
        wait_done(W + 4);
        chk("t1_latency", 64'(cyc - start_cyc), 64'(W));
        chk("t1_product", 64'(product), 64'hFFF4);
`ifdef BOOTH_OPCOUNT_EN
        chk("t1_op_count", 64'(op_count), 64'd1);
`endif

        // -128 * -128 = +16384
        @(negedge clk);
        do_start(8'h80, 8'h80);
        wait_done(W + 4);
        chk("t2_product", 64'(product), 64'h4000);
`ifdef BOOTH_OPCOUNT_EN
        chk("t2_op_count", 64'(op_count), 64'd1);
`endif

        // 127 * -128, then back-to-back 5 * 0x55 started in the done cycle.
        @(negedge clk);
        do_start(8'd127, 8'h80);
        wait_done(W + 4);
        chk("t3_product", 64'(product), 64'hC080);
        do_start(8'd5, 8'h55);
        chk("t3_b2b_latency_busy", 64'(busy), 64'd1);
        wait_done(W + 4);
        chk("t3_b2b_latency", 64'(cyc - start_cyc), 64'(W));
        chk("t3_b2b_product", 64'(product), 64'h01A9);
`ifdef BOOTH_OPCOUNT_EN
        chk("t3_b2b_op_count", 64'(op_count), 64'd8);
`endif

        // 7 * 9 aborted by a one-edge reset at cycle 4, then redone.
        @(negedge clk);
        do_start(8'd7, 8'd9);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t5_abort_busy", 64'(busy), 64'd0);
        chk("t5_abort_product", 64'(product), 64'd0);
        chk("t5_abort_done", 64'(done), 64'd0);
        repeat (W + 2) @(negedge clk);
        do_start(8'd7, 8'd9);
        wait_done(W + 4);
        chk("t5_product", 64'(product), 64'h003F);

        // 0x5A * 0 with start and operands toggling while busy.
        @(negedge clk);
        do_start(8'h5A, 8'h00);
        for (int i = 0; i < W - 2; i++) begin
            @(posedge clk); #1;
            start = 1'($urandom_range(0, 1));
            multiplicand = W'($urandom);
            multiplier = W'($urandom);
        end
        start = 1'b0;
        wait_done(W + 4);
        chk("t4_product", 64'(product), 64'h0000);
`ifdef BOOTH_OPCOUNT_EN
        chk("t4_op_count", 64'(op_count), 64'd0);
`endif
        repeat (3) @(negedge clk);

        // Randomized signed pairs, with extremes mixed in and random idle gaps.
        for (int n = 0; n < 1000; n++) begin
            logic [W-1:0] a, b;
            int gap;
            case ($urandom_range(0, 7))
                0: a = 8'h80;
                1: a = 8'h7F;
                2: a = 8'hFF;
                default: a = W'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0: b = 8'h80;
                1: b = 8'h7F;
                2: b = 8'h00;
                default: b = W'($urandom);
            endcase
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            do_start(a, b);
            wait_done(W + 4);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "time limit reached");
    end

endmodule
